// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_ctrl_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK  = 7'b000_0000;
    localparam logic [6:0] SEG_ALL_ON = 7'b111_1111;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-value write channel: valid/ready handshake with value and dp.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [4*NUM_DIGITS-1:0] wr_value;
    logic [NUM_DIGITS-1:0]   wr_dp;

    modport master (
        output wr_valid,
        output wr_value,
        output wr_dp,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_value,
        input  wr_dp,
        output wr_ready
    );
endinterface

// File: rtl/seg_scan_ctrl_segfont.sv
// Hex nibble to seven-segment pattern, segments a..g in bits 6..0.
module segfont
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        unique case (nibble)
            4'h0: seg = 7'b111_1110;
            4'h1: seg = 7'b011_0000;
            4'h2: seg = 7'b110_1101;
            4'h3: seg = 7'b111_1001;
            4'h4: seg = 7'b011_0011;
            4'h5: seg = 7'b101_1011;
            4'h6: seg = 7'b101_1111;
            4'h7: seg = 7'b111_0000;
            4'h8: seg = SEG_ALL_ON;
            4'h9: seg = 7'b111_1011;
            4'hA: seg = 7'b111_0111;
            4'hB: seg = 7'b001_1111;
            4'hC: seg = 7'b100_1110;
            4'hD: seg = 7'b011_1101;
            4'hE: seg = 7'b100_1111;
            4'hF: seg = 7'b100_0111;
        endcase
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-synchronous double buffering.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 27000,
    parameter int BLANK_CYCLES   = 270,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    seg_scan_ctrl_if.slave        wr,
    input  logic                  lz_en,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [NUM_DIGITS-1:0] dig_o,
    output logic                  frame_o
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] DIG_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? SEG_ALL_ON : SEG_BLANK;
    localparam logic       DP_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_INV = {NUM_DIGITS{DIG_ACTIVE_LOW != 0}};

    logic [CW-1:0]           cnt_q, cnt_n;
    logic [IW-1:0]           idx_q, idx_n;
    state_t                  state_q, state_n;
    logic [4*NUM_DIGITS-1:0] sh_val, act_val;
    logic [NUM_DIGITS-1:0]   sh_dp, act_dp;
    logic                    pend;
    logic                    hs, frame_start, drive;
    logic [3:0]              nib;
    logic                    nib_dp, lz_blank;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic [6:0]              font;

    assign wr.wr_ready   = !pend;
    assign hs            = wr.wr_valid && !pend;
    assign frame_start   = (cnt_q == '0) && (idx_q == '0);

    always_comb begin
        cnt_n = cnt_q + 1'b1;
        idx_n = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_n = '0;
            idx_n = (idx_q == DIG_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= ST_BLANK;
        else            state_q <= state_n;
    end

    // State tracks the slot count it will hold next cycle.
    always_comb begin
        state_n = state_q;
        drive   = 1'b0;
        unique case (state_q)
            ST_BLANK: begin
                if (cnt_n >= CNT_BLANK) state_n = ST_DRIVE;
            end
            ST_DRIVE: begin
                drive = 1'b1;
                if (cnt_n == '0 && CNT_BLANK != '0) state_n = ST_BLANK;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            pend    <= 1'b0;
            sh_val  <= '0;
            sh_dp   <= '0;
            act_val <= '0;
            act_dp  <= '0;
        end else begin
            cnt_q <= cnt_n;
            idx_q <= idx_n;
            if (frame_start && pend) begin
                act_val <= sh_val;
                act_dp  <= sh_dp;
                pend    <= 1'b0;
            end else if (hs) begin
                sh_val <= wr.wr_value;
                sh_dp  <= wr.wr_dp;
                pend   <= 1'b1;
            end
        end
    end

    // A digit is suppressed only when it and every digit to its left are zero.
    always_comb begin
        nib      = 4'h0;
        nib_dp   = 1'b0;
        dig_sel  = '0;
        lz_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                nib        = act_val[4*k +: 4];
                nib_dp     = act_dp[k];
                dig_sel[k] = 1'b1;
                lz_blank   = lz_en && (k != 0) &&
                             ((act_val >> (4*k)) == '0);
            end
        end
    end

    segfont u_font (
        .nibble (nib),
        .seg    (font)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            seg_o   <= SEG_INV;
            dp_o    <= DP_INV;
            dig_o   <= DIG_INV;
            frame_o <= 1'b0;
        end else begin
            seg_o   <= ((drive && !lz_blank) ? font : SEG_BLANK) ^ SEG_INV;
            dp_o    <= (drive && nib_dp) ^ DP_INV;
            dig_o   <= (drive ? dig_sel : '0) ^ DIG_INV;
            frame_o <= frame_start;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: vector table, corner sequences, random run.
module tb_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FR = ND * SD;

    localparam logic [6:0] FONT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dp;
        logic            lz;
        logic [3:0][6:0] seg;
        logic [3:0]      dpo;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lz_en = 1'b0;
    logic [6:0]    seg_o;
    logic          dp_o;
    logic [ND-1:0] dig_o;
    logic          frame_o;

    seg_scan_ctrl_if #(.NUM_DIGITS(ND)) wr_if ();

    seg_scan_ctrl #(
        .NUM_DIGITS     (ND),
        .SCAN_DIV       (SD),
        .BLANK_CYCLES   (BC),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .wr        (wr_if),
        .lz_en     (lz_en),
        .seg_o     (seg_o),
        .dp_o      (dp_o),
        .dig_o     (dig_o),
        .frame_o   (frame_o)
    );

    always #5 clk = ~clk;

    // Reference model: frame position plus shadow/active buffers.
    int          t;
    logic [15:0] av, sv;
    logic [3:0]  adp, sdp;
    logic        pend, acc;
    int          last_pos;
    int          n_cmp, n_err;
    vec_t        vec [6];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        logic [6:0] es;
        logic       ed, ef, drv, sup;
        logic [3:0] eg;
        int         d, s;
        es = 7'h7F; ed = 1'b1; eg = 4'hF; ef = 1'b0;
        last_pos = -1;
        acc = 1'b0;
        if (rst_n) begin
            d = t / SD;
            s = t % SD;
            drv = (s >= BC);
            sup = lz_en && (d > 0) && ((av >> (4*d)) == 16'h0);
            if (drv) begin
                es = (sup ? 7'h00 : FONT[av[4*d +: 4]]) ^ 7'h7F;
                ed = ~adp[d];
                eg = ~(4'b0001 << d);
            end
            ef = (t == 0);
            last_pos = t;
            if (t == 0 && pend) begin
                av = sv; adp = sdp; pend = 1'b0;
            end else if (wr_if.wr_valid && !pend) begin
                sv = wr_if.wr_value; sdp = wr_if.wr_dp;
                pend = 1'b1; acc = 1'b1;
            end
            t = (t + 1) % FR;
        end else begin
            t = 0; av = '0; adp = '0; pend = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("seg_o", seg_o, es);
        chk("dp_o", dp_o, ed);
        chk("dig_o", dig_o, eg);
        chk("frame_o", frame_o, ef);
        chk("wr_ready", wr_if.wr_ready, !pend);
    endtask

    task automatic offer(input logic [15:0] v, input logic [3:0] p);
        int n;
        n = 0;
        wr_if.wr_value = v;
        wr_if.wr_dp    = p;
        wr_if.wr_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!acc && n < 200);
        wr_if.wr_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: value 0x%0h not taken", v);
        end else begin
            chk("ready_after_hs", wr_if.wr_ready, 1'b0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int frames, waitn;
        int lo [ND];
        vec[0] = '{16'h1234, 4'b0000, 1'b0,
                   {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1111};
        vec[1] = '{16'h0070, 4'b0100, 1'b1,
                   {7'b1111111, 7'b1111111, 7'b0001111, 7'b0000001}, 4'b1011};
        vec[2] = '{16'h8F0A, 4'b1001, 1'b1,
                   {7'b0000000, 7'b0111000, 7'b0000001, 7'b0001000}, 4'b0110};
        vec[3] = '{16'h0000, 4'b0000, 1'b1,
                   {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b1111};
        vec[4] = '{16'hBCDE, 4'b1111, 1'b0,
                   {7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000}, 4'b0000};
        vec[5] = '{16'h0005, 4'b0010, 1'b0,
                   {7'b0000001, 7'b0000001, 7'b0000001, 7'b0100100}, 4'b1101};

        wr_if.wr_valid = 1'b0;
        wr_if.wr_value = '0;
        wr_if.wr_dp    = '0;
        t = 0; av = '0; adp = '0; sv = '0; sdp = '0;
        pend = 1'b0; acc = 1'b0; last_pos = -1;
        n_cmp = 0; n_err = 0;

        repeat (3) tick();
        rst_n = 1'b1;

        // First frame pulse one cycle after release, then every frame.
        tick();
        chk("first_frame", frame_o, 1'b1);
        frames = 1;
        for (int d = 0; d < ND; d++) lo[d] = dig_o[d] ? 0 : 1;
        repeat (2*FR - 1) begin
            tick();
            frames += frame_o ? 1 : 0;
            for (int d = 0; d < ND; d++) lo[d] += dig_o[d] ? 0 : 1;
        end
        chk("frame_count", frames, 2);
        for (int d = 0; d < ND; d++) chk("dig_low_cycles", lo[d], 2*(SD-BC));

        // Handshake exactly in the frame-start cycle waits a whole frame.
        waitn = 0;
        while (!(t == 0 && !pend) && waitn < 100) begin
            tick();
            waitn++;
        end
        wr_if.wr_value = 16'hC0DE;
        wr_if.wr_dp    = 4'b0000;
        wr_if.wr_valid = 1'b1;
        tick();
        wr_if.wr_valid = 1'b0;
        chk("fs_ready_low", wr_if.wr_ready, 1'b0);
        repeat (FR - 1) tick();
        chk("fs_no_early_swap", wr_if.wr_ready, 1'b0);
        tick();
        chk("fs_swap", wr_if.wr_ready, 1'b1);

        // Back-to-back writes with the second held valid.
        offer(16'hAAAA, 4'b0101);
        offer(16'h5555, 4'b1010);
        repeat (2*FR) tick();

        foreach (vec[i]) begin
            lz_en = vec[i].lz;
            offer(vec[i].val, vec[i].dp);
            repeat (2*FR) tick();
            repeat (FR) begin
                tick();
                if (last_pos >= 0 && last_pos % SD == 4) begin
                    chk("tbl_seg", seg_o, vec[i].seg[last_pos/SD]);
                    chk("tbl_dp", dp_o, vec[i].dpo[last_pos/SD]);
                end
            end
        end
        lz_en = 1'b0;

        // Reset during digit 2 drive with a pending value.
        waitn = 0;
        while (!(t == 1 && !pend) && waitn < 100) begin
            tick();
            waitn++;
        end
        offer(16'h9999, 4'b1111);
        waitn = 0;
        while (t != 2*SD + 5 && waitn < 100) begin
            tick();
            waitn++;
        end
        chk("pend_before_rst", wr_if.wr_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_seg", seg_o, 7'h7F);
        chk("rst_dp", dp_o, 1'b1);
        chk("rst_dig", dig_o, 4'hF);
        chk("rst_frame", frame_o, 1'b0);
        chk("rst_ready", wr_if.wr_ready, 1'b1);
        t = 0; av = '0; adp = '0; pend = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (FR) begin
            tick();
            if (last_pos == 4) chk("post_rst_digit0", seg_o, 7'b0000001);
        end

        for (int i = 0; i < 3000; i++) begin
            wr_if.wr_valid = ($urandom_range(0, 3) == 0);
            wr_if.wr_value = ($urandom_range(0, 2) == 0) ?
                             16'($urandom_range(0, 255)) : 16'($urandom);
            wr_if.wr_dp    = 4'($urandom);
            if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
            if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
            else if (!rst_n && $urandom_range(0, 2) == 0) rst_n = 1'b1;
            tick();
        end
        wr_if.wr_valid = 1'b0;
        rst_n = 1'b1;
        repeat (FR) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
